// File: rtl/perceptron_trainer.sv
// perceptron_trainer: buffers signed training samples, then runs perceptron
// learning epochs until an error-free epoch or the epoch limit is reached.
// Weights and bias saturate to the WW signed range; status is held at DONE.
module perceptron_trainer #(
  parameter int N_IN      = 2,
  parameter int XW        = 8,
  parameter int WW        = 16,
  parameter int DEPTH     = 8,
  parameter int LR        = 1,
  parameter int MAX_EPOCH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [N_IN*XW-1:0]             s_x,
  input  logic [1:0]                     s_t,
  input  logic                           flush,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           converged,
  output logic [$clog2(MAX_EPOCH+1)-1:0] epoch_count,
  output logic [$clog2(DEPTH+1)-1:0]     err_count,
  output logic [N_IN*WW-1:0]             w_out,
  output logic [WW-1:0]                  b_out
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $clog2(MAX_EPOCH+1);
  localparam int IW = $clog2(DEPTH);
  // net width: products plus bias summed without overflow
  localparam int NW = XW + WW + $clog2(N_IN+1);
  // update width: weight plus LR*x before clamping, with headroom
  localparam int UW = XW + WW + $clog2(LR+1) + 1;

  localparam logic signed [UW-1:0] LR_U    = UW'(LR);
  localparam logic signed [UW-1:0] SAT_MAX = {{(UW-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [UW-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EVAL   = 3'd1;
  localparam logic [2:0] S_UPDATE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                       state_q, state_d;
  logic [CW-1:0]                    count_q, count_d;
  logic [DEPTH-1:0][N_IN*XW-1:0]    xmem_q, xmem_d;
  logic [DEPTH-1:0]                 tmem_q, tmem_d;   // 1 = target -1
  logic [IW-1:0]                    idx_q, idx_d;
  logic                             err_q, err_d;
  logic [N_IN-1:0][WW-1:0]          w_q, w_d;
  logic [WW-1:0]                    b_q, b_d;
  logic [EW-1:0]                    epoch_q, epoch_d;
  logic [CW-1:0]                    errcnt_q, errcnt_d;
  logic                             conv_q, conv_d;

  logic [N_IN*XW-1:0]               cur_x;
  logic                             cur_tneg;
  logic [N_IN-1:0][NW-1:0]          prod;
  logic [N_IN-1:0][WW-1:0]          w_upd;
  logic [WW-1:0]                    b_upd;
  logic signed [WW-1:0]             b_s;
  logic signed [UW-1:0]             b_sum;
  logic signed [NW-1:0]             net;
  logic [EW-1:0]                    epoch_inc;
  logic                             ctl_state;
  logic                             last_idx;
  logic                             unused_t0;

  // Only the sign bit of the target encoding carries information
  assign unused_t0 = s_t[0];

  function automatic logic [WW-1:0] sat(input logic signed [UW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WW-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WW-1:0];
    else                  sat = v[WW-1:0];
  endfunction

  assign cur_x     = xmem_q[idx_q];
  assign cur_tneg  = tmem_q[idx_q];
  assign b_s       = b_q;
  assign ctl_state = (state_q == S_IDLE) || (state_q == S_DONE);
  assign s_ready   = ctl_state && (count_q < CW'(DEPTH));
  assign last_idx  = (CW'(idx_q) == count_q - CW'(1));
  assign epoch_inc = epoch_q + EW'(1);

  // Per-input product for the net sum and the saturated learning step
  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    logic signed [XW-1:0] xi;
    logic signed [WW-1:0] wi;
    logic signed [NW-1:0] p;
    logic signed [UW-1:0] step;
    logic signed [UW-1:0] sum;
    assign xi       = cur_x[i*XW +: XW];
    assign wi       = w_q[i];
    assign p        = NW'(xi) * NW'(wi);
    assign prod[i]  = p;
    assign step     = LR_U * UW'(xi);
    assign sum      = UW'(wi) + (cur_tneg ? -step : step);
    assign w_upd[i] = sat(sum);
  end

  assign b_sum = UW'(b_s) + (cur_tneg ? -LR_U : LR_U);
  assign b_upd = sat(b_sum);

  // Full-width net = bias + sum of x[i]*w[i]
  always_comb begin
    net = NW'(b_s);
    for (int i = 0; i < N_IN; i++) net = net + $signed(prod[i]);
  end

  // Loading, control and epoch sequencing
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    xmem_d   = xmem_q;
    tmem_d   = tmem_q;
    idx_d    = idx_q;
    err_d    = err_q;
    w_d      = w_q;
    b_d      = b_q;
    epoch_d  = epoch_q;
    errcnt_d = errcnt_q;
    conv_d   = conv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // flush beats a same-cycle sample and also clears done
        if (flush) begin
          count_d = '0;
          state_d = S_IDLE;
        end else if (s_valid && s_ready) begin
          xmem_d[count_q[IW-1:0]] = s_x;
          tmem_d[count_q[IW-1:0]] = s_t[1];
          count_d = count_q + CW'(1);
        end
        if (start) begin
          epoch_d  = '0;
          errcnt_d = '0;
          conv_d   = 1'b0;
          if (flush || count_q == '0) begin
            state_d = S_DONE;
          end else begin
            w_d     = '0;
            b_d     = '0;
            idx_d   = '0;
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        // y is -1 exactly when net is negative
        err_d   = net[NW-1] ^ cur_tneg;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (err_q) begin
          w_d      = w_upd;
          b_d      = b_upd;
          errcnt_d = errcnt_q + CW'(1);
        end
        if (last_idx) begin
          state_d = S_CHECK;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_EVAL;
        end
      end
      S_CHECK: begin
        epoch_d = epoch_inc;
        if (errcnt_q == '0) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (epoch_inc == EW'(MAX_EPOCH)) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d    = '0;
          errcnt_d = '0;
          state_d  = S_EVAL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything including the buffer count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      xmem_q   <= '0;
      tmem_q   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      w_q      <= '0;
      b_q      <= '0;
      epoch_q  <= '0;
      errcnt_q <= '0;
      conv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      xmem_q   <= xmem_d;
      tmem_q   <= tmem_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      w_q      <= w_d;
      b_q      <= b_d;
      epoch_q  <= epoch_d;
      errcnt_q <= errcnt_d;
      conv_q   <= conv_d;
    end
  end

  assign busy        = (state_q == S_EVAL) || (state_q == S_UPDATE) || (state_q == S_CHECK);
  assign done        = (state_q == S_DONE);
  assign converged   = conv_q;
  assign epoch_count = epoch_q;
  assign err_count   = errcnt_q;
  assign w_out       = w_q;
  assign b_out       = b_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: table of training sets checked through an
// expected-result queue, plus hand sequences for control corner cases and a
// narrow-weight instance for saturation.
module tb_perceptron_trainer;

  typedef struct packed {
    logic [3:0][1:0][7:0] x;
    logic [3:0]           tn;
    logic                 conv;
    logic [7:0]           ep;
    logic [15:0]          w0;
    logic [15:0]          w1;
    logic [15:0]          b;
    logic [7:0]           err;
    logic                 chk_w;
    logic                 err_any;
    logic [7:0]           cyc;
  } vec_t;

  logic        clk, reset;
  logic        s_valid, s_ready, flush, start, busy, done, converged;
  logic [15:0] s_x;
  logic [1:0]  s_t;
  logic [3:0]  epoch_count;
  logic [2:0]  err_count;
  logic [31:0] w_out;
  logic [15:0] b_out;

  logic        s_valid2, s_ready2, flush2, start2, busy2, done2, converged2;
  logic [1:0]  epoch_count2;
  logic [2:0]  err_count2;
  logic [7:0]  w_out2;
  logic [3:0]  b_out2;

  int   n_tests, n_fail;
  vec_t tv[3];
  vec_t exp_q[$];

  perceptron_trainer #(.N_IN(2), .XW(8), .WW(16), .DEPTH(4), .LR(1), .MAX_EPOCH(8)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_t(s_t),
    .flush(flush), .start(start), .busy(busy), .done(done), .converged(converged),
    .epoch_count(epoch_count), .err_count(err_count), .w_out(w_out), .b_out(b_out));

  perceptron_trainer #(.N_IN(2), .XW(8), .WW(4), .DEPTH(4), .LR(4), .MAX_EPOCH(3)) dut_sat (
    .clk(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2), .s_x(s_x), .s_t(s_t),
    .flush(flush2), .start(start2), .busy(busy2), .done(done2), .converged(converged2),
    .epoch_count(epoch_count2), .err_count(err_count2), .w_out(w_out2), .b_out(b_out2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t smp(input vec_t v, input int k, input int x0, input int x1, input int tn);
    v.x[k][0] = x0[7:0];
    v.x[k][1] = x1[7:0];
    v.tn[k]   = tn[0];
    return v;
  endfunction

  function automatic vec_t res(input vec_t v, input bit conv, input int ep, input int w0, input int w1,
                               input int b, input int err, input bit chk_w, input bit err_any, input int cyc);
    v.conv = conv; v.ep = ep[7:0]; v.w0 = w0[15:0]; v.w1 = w1[15:0]; v.b = b[15:0];
    v.err = err[7:0]; v.chk_w = chk_w; v.err_any = err_any; v.cyc = cyc[7:0];
    return v;
  endfunction

  task automatic drive_sample(input int x0, input int x1, input int tn);
    s_x = {x1[7:0], x0[7:0]};
    s_t = tn[0] ? 2'b11 : 2'b01;
  endtask

  task automatic push_sample(input int x0, input int x1, input int tn);
    drive_sample(x0, x1, tn);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    do_flush();
    for (int k = 0; k < 4; k++)
      push_sample($signed(v.x[k][0]), $signed(v.x[k][1]), int'(v.tn[k]));
  endtask

  task automatic empty_start(input string nm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " done"}, done, 1);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " converged"}, converged, 0);
    chk({nm, " epoch_count"}, epoch_count, 0);
  endtask

  // Push the expected result at start, pop and compare when done appears
  task automatic run_train(input string nm, input vec_t e, input int glitch);
    vec_t ex;
    int   cnt;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy_rise"}, busy, 1);
    chk({nm, " done_drop"}, done, 0);
    cnt = 0;
    while (!done && cnt < 400) begin
      if (cnt == glitch) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end
    ex = exp_q.pop_front();
    chk({nm, " done"}, done, 1);
    chk({nm, " cycles"}, cnt, int'(ex.cyc));
    chk({nm, " converged"}, converged, int'(ex.conv));
    chk({nm, " epoch_count"}, epoch_count, int'(ex.ep));
    if (ex.err_any) chk({nm, " err_count_nonzero"}, int'(err_count != 0), 1);
    else            chk({nm, " err_count"}, err_count, int'(ex.err));
    if (ex.chk_w) begin
      chk({nm, " w0"}, $signed(w_out[15:0]), $signed(ex.w0));
      chk({nm, " w1"}, $signed(w_out[31:16]), $signed(ex.w1));
      chk({nm, " b"}, $signed(b_out), $signed(ex.b));
    end
  endtask

  initial begin
    int acc, cnt;
    clk = 1'b0; reset = 1'b0;
    s_valid = 1'b0; flush = 1'b0; start = 1'b0; s_x = '0; s_t = 2'b01;
    s_valid2 = 1'b0; flush2 = 1'b0; start2 = 1'b0;
    n_tests = 0; n_fail = 0;

    // AND, OR, XOR (1 in the tn column means target -1)
    tv[0] = '0;
    tv[0] = smp(tv[0], 0, 1, 1, 0);  tv[0] = smp(tv[0], 1, 1, -1, 1);
    tv[0] = smp(tv[0], 2, -1, 1, 1); tv[0] = smp(tv[0], 3, -1, -1, 1);
    tv[0] = res(tv[0], 1, 3, 1, 1, -1, 0, 1, 0, 27);
    tv[1] = '0;
    tv[1] = smp(tv[1], 0, 1, 1, 0);  tv[1] = smp(tv[1], 1, 1, -1, 0);
    tv[1] = smp(tv[1], 2, -1, 1, 0); tv[1] = smp(tv[1], 3, -1, -1, 1);
    tv[1] = res(tv[1], 1, 3, 1, 1, 1, 0, 1, 0, 27);
    tv[2] = '0;
    tv[2] = smp(tv[2], 0, 1, 1, 1);  tv[2] = smp(tv[2], 1, 1, -1, 0);
    tv[2] = smp(tv[2], 2, -1, 1, 0); tv[2] = smp(tv[2], 3, -1, -1, 1);
    tv[2] = res(tv[2], 0, 8, 0, 0, 0, 0, 0, 1, 72);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset s_ready", s_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset converged", converged, 0);
    chk("reset epoch_count", epoch_count, 0);
    chk("reset w_out", int'(w_out), 0);
    chk("reset s_ready2", s_ready2, 1);

    empty_start("empty_start");

    for (int v = 0; v < 3; v++) begin
      load_vec(tv[v]);
      run_train($sformatf("table%0d", v), tv[v], -1);
    end

    // Backpressure: six offers into a four-entry buffer
    do_flush();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive_sample($signed(tv[0].x[k][0]), $signed(tv[0].x[k][1]), int'(tv[0].tn[k]));
      else       drive_sample(5, 5, 0);
      s_valid = 1'b1;
      chk($sformatf("bp s_ready offer%0d", k), s_ready, (k < 4) ? 1 : 0);
      if (s_ready) acc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("bp accepts", acc, 4);
    run_train("bp_stored", tv[0], -1);
    run_train("bp_retrain", tv[0], -1);
    do_flush();
    chk("flush s_ready", s_ready, 1);
    chk("flush done_drop", done, 0);
    empty_start("after_flush");

    // Simultaneous flush+start behaves as an empty start
    load_vec(tv[0]);
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_start done", done, 1);
    chk("flush_start converged", converged, 0);
    chk("flush_start epoch_count", epoch_count, 0);
    chk("flush_start s_ready", s_ready, 1);

    // start pulse while busy must not disturb training
    load_vec(tv[0]);
    run_train("start_glitch", tv[0], 5);

    // Asynchronous reset during the second epoch
    load_vec(tv[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (epoch_count != 4'd1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid epoch reached", epoch_count, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset epoch_count", epoch_count, 0);
    chk("async reset err_count", err_count, 0);
    chk("async reset w_out", int'(w_out), 0);
    chk("async reset b_out", int'(b_out), 0);
    chk("async reset converged", converged, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    empty_start("post_reset_empty");
    load_vec(tv[0]);
    run_train("post_reset_and", tv[0], -1);

    // Saturation on the 4-bit weight instance, LR=4
    chk("sat s_ready2", s_ready2, 1);
    drive_sample(-7, 0, 1); s_valid2 = 1'b1; @(negedge clk);
    drive_sample(7, 0, 1);  @(negedge clk);
    s_valid2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("sat busy2", busy2, 1);
    repeat (2) @(negedge clk);
    chk("sat w0 clamp hi", $signed(w_out2[3:0]), 7);
    chk("sat b step", $signed(b_out2), -4);
    repeat (2) @(negedge clk);
    chk("sat w0 clamp lo", $signed(w_out2[3:0]), -8);
    chk("sat b clamp", $signed(b_out2), -8);
    cnt = 0;
    while (!done2 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("sat done2", done2, 1);
    chk("sat converged2", converged2, 0);
    chk("sat epoch_count2", epoch_count2, 3);
    chk("sat err_count2", err_count2, 2);
    chk("sat final w0", $signed(w_out2[3:0]), -8);
    chk("sat final w1", $signed(w_out2[7:4]), 0);
    chk("sat final b", $signed(b_out2), -8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
